instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DEPTH, default 2; maximum in-flight instruction fetches plus buffered instructions (power of two, >= 2).
REQ-002 Parameter AW, default 32; instruction address and data width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 pc_in  input  AW  word address of the next instruction, from the program-counter stage.
REQ-006 pc_valid  input  1  pc_in is valid.
REQ-007 pc_ready  output  1  fetch accepts pc_in this cycle; PC stage advances only on pc_valid && pc_ready.
REQ-008 flush  input  1  taken branch/redirect; discards all older fetches.
REQ-009 imem_req  output  1  instruction-memory read request.
REQ-010 imem_addr  output  AW  request address.
REQ-011 imem_gnt  input  1  memory accepts the request this cycle.
REQ-012 imem_rvalid  input  1  read data returned, in request order, latency >= 1 cycle.
REQ-013 imem_rdata  input  AW  returned instruction word.
REQ-014 if_valid  output  1  if_instr/if_pc hold a valid instruction for decode.
REQ-015 if_instr  output  AW  instruction word.
REQ-016 if_pc  output  AW  address the instruction came from.
REQ-017 id_ready  input  1  decode consumes the head entry this cycle.
REQ-018 err_unexp  output  1  sticky: imem_rvalid seen with no fetch outstanding.

Function
REQ-019 Fetch SHALL keep counters outst (issued, not returned), qcnt (buffered instructions) and drop (returns to discard), each clog2(DEPTH+1) bits.
REQ-020 credit SHALL be (outst + qcnt) < DEPTH, using registered values only.
REQ-021 imem_req SHALL equal pc_valid && credit && !flush && !reset; imem_addr SHALL equal pc_in (combinational).
REQ-022 pc_ready SHALL equal imem_req && imem_gnt; a handshake occurs only when both are 1.
REQ-023 On handshake, pc_in SHALL be pushed into an internal DEPTH-entry tag FIFO and outst incremented.
REQ-024 On imem_rvalid with outst > 0: pop tag FIFO, decrement outst; if drop > 0 decrement drop and discard, else push {tag, imem_rdata} into the DEPTH-entry output queue.
REQ-025 Handshake and imem_rvalid in the same cycle SHALL both take effect (outst unchanged net).
REQ-026 if_valid SHALL be qcnt != 0; if_instr/if_pc SHALL be the queue head (registered, no combinational path from imem_rdata).
REQ-027 Head SHALL be popped when if_valid && id_ready; push and pop in the same cycle SHALL both occur (qcnt unchanged).
REQ-028 Credit rule SHALL guarantee the queue never overflows; no data lost when id_ready is held 0 indefinitely.
REQ-029 On flush: output queue emptied (qcnt=0, if_valid=0 next cycle); drop set to outst minus one if imem_rvalid is accepted for discard-eligible data in that same cycle, else outst; no request issued.
REQ-030 A response arriving in the flush cycle SHALL be discarded, never enqueued.
REQ-031 imem_rvalid with outst == 0 SHALL be ignored (no counter/queue change) and set err_unexp until reset.
REQ-032 Pointers SHALL wrap modulo DEPTH; counters SHALL never exceed DEPTH nor underflow.
REQ-033 Instructions SHALL reach decode in exactly request order; first instruction visible on if_valid one cycle after its imem_rvalid.

Reset
REQ-034 While reset is 1 at a clock edge: outst, qcnt, drop, FIFO pointers, err_unexp = 0; if_valid = 0; if_instr, if_pc = 0.
REQ-035 During reset imem_req and pc_ready SHALL be 0; reset mid-operation abandons all in-flight fetches (memory is reset by the same signal).

Verification
REQ-036 Single fetch: pc_in=0x10, gnt=1, rvalid one cycle later with rdata=0xDEADBEEF -> next cycle if_valid=1, if_pc=0x10, if_instr=0xDEADBEEF.
REQ-037 Back-pressure: id_ready=0, PCs 0,1,2 offered, gnt=1 -> only 0 and 1 accepted (pc_ready=0 for 2 with DEPTH=2); releasing id_ready delivers 0 then 1, then 2 is accepted.
REQ-038 Flush with 2 outstanding (PCs 4,5), flush pulsed, redirect PC 0x40 fetched -> responses for 4,5 discarded, decode sees only 0x40.
REQ-039 Simultaneous push/pop: continuous gnt/rvalid, id_ready=1, PCs 0..7 -> if_valid stays 1 after fill, one instruction per cycle, order 0..7.
REQ-040 Spurious rvalid after reset with nothing issued -> err_unexp=1, if_valid stays 0; subsequent reset clears err_unexp.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit.
// Issues word-address reads to instruction memory. Each accepted address is
// remembered in a tag FIFO. Each returned word is paired with its address and
// placed in an output queue, which decode drains one entry at a time.
// A shared credit limits in-flight fetches plus buffered entries to DEPTH, so
// the output queue can never overflow.
// After a flush, responses that are still in flight are counted off and
// thrown away.
module instr_fetch #(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_in,
  input  logic          pc_valid,
  output logic          pc_ready,
  input  logic          flush,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [AW-1:0] imem_rdata,
  output logic          if_valid,
  output logic [AW-1:0] if_instr,
  output logic [AW-1:0] if_pc,
  input  logic          id_ready,
  output logic          err_unexp
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW:0]   C_DEPTH = (CW + 1)'(DEPTH);

  // Counters
  logic [CW-1:0] r_outst;   // issued, not yet returned
  logic [CW-1:0] r_qcnt;    // entries held in the output queue
  logic [CW-1:0] r_drop;    // returns still owed from before a flush
  logic          r_err;

  // Tag FIFO: addresses of fetches in flight, in issue order
  logic [AW-1:0] r_tag_mem [DEPTH];
  logic [PW-1:0] r_tag_wr;
  logic [PW-1:0] r_tag_rd;

  // Output queue: {pc, instr} pairs waiting for decode
  logic [AW-1:0] r_q_pc    [DEPTH];
  logic [AW-1:0] r_q_instr [DEPTH];
  logic [PW-1:0] r_q_wr;
  logic [PW-1:0] r_q_rd;

  logic [CW:0] w_used;
  logic        w_credit;
  logic        w_hs;
  logic        w_rsp;
  logic        w_enq;
  logic        w_deq;

  // Request handshake and the per-cycle events derived from it
  always_comb begin
    w_used    = {1'b0, r_outst} + {1'b0, r_qcnt};
    w_credit  = w_used < C_DEPTH;
    imem_req  = pc_valid && w_credit && !flush && !reset;
    imem_addr = pc_in;
    pc_ready  = imem_req && imem_gnt;
    w_hs      = pc_ready;
    w_rsp     = imem_rvalid && (r_outst != '0);
    w_enq     = w_rsp && (r_drop == '0) && !flush;
    w_deq     = if_valid && id_ready && !flush;
    if_valid  = r_qcnt != '0;
    if_pc     = r_q_pc[r_q_rd];
    if_instr  = r_q_instr[r_q_rd];
    err_unexp = r_err;
  end

  // Counters, pointers and the sticky error flag
  always_ff @(posedge clk) begin
    // NOTE: every register here is written with <= so all of them update from
    // the same pre-edge values; with = a later line would see an earlier update.
    if (reset) begin
      r_outst  <= '0;
      r_qcnt   <= '0;
      r_drop   <= '0;
      r_err    <= 1'b0;
      r_tag_wr <= '0;
      r_tag_rd <= '0;
      r_q_wr   <= '0;
      r_q_rd   <= '0;
    end else begin
      case ({w_hs, w_rsp})
        2'b10:   r_outst <= r_outst + C_ONE;
        2'b01:   r_outst <= r_outst - C_ONE;
        default: r_outst <= r_outst;
      endcase

      if (flush)
        r_drop <= w_rsp ? (r_outst - C_ONE) : r_outst;
      else if (w_rsp && (r_drop != '0))
        r_drop <= r_drop - C_ONE;

      if (w_hs)  r_tag_wr <= r_tag_wr + 1'b1;
      if (w_rsp) r_tag_rd <= r_tag_rd + 1'b1;

      if (flush) begin
        r_qcnt <= '0;
        r_q_wr <= '0;
        r_q_rd <= '0;
      end else begin
        case ({w_enq, w_deq})
          2'b10:   r_qcnt <= r_qcnt + C_ONE;
          2'b01:   r_qcnt <= r_qcnt - C_ONE;
          default: r_qcnt <= r_qcnt;
        endcase
        if (w_enq) r_q_wr <= r_q_wr + 1'b1;
        if (w_deq) r_q_rd <= r_q_rd + 1'b1;
      end

      if (imem_rvalid && (r_outst == '0))
        r_err <= 1'b1;
    end
  end

  // Tag storage: written on handshake, read only while a fetch is in flight
  always_ff @(posedge clk) begin
    // NOTE: this storage has no reset because the pointers alone decide which
    // entries are live. The output queue below is cleared only so that
    // if_pc and if_instr read as zero out of reset.
    if (w_hs)
      r_tag_mem[r_tag_wr] <= pc_in;
  end

  // Output queue storage: captures the tag and returned word on enqueue
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
      end
    end else if (w_enq) begin
      r_q_pc[r_q_wr]    <= r_tag_mem[r_tag_rd];
      r_q_instr[r_q_wr] <= imem_rdata;
    end
  end

endmodule
